// File: rtl/pic_pkg.sv
// Shared definitions for the interrupt controller slice.
//   ack_state_t      : acknowledge sequencer states
//   level_t          : 3-bit interrupt level (0..7)
//   SPURIOUS_LEVEL   : level reported when no request is present at acknowledge
//   onehot_to_level  : one-hot request/ISR vector -> level index
//   level_to_onehot  : level index -> one-hot vector
package pic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PENDING,
    ST_ACK1,
    ST_GAP,
    ST_ACK2
  } ack_state_t;

  typedef logic [2:0] level_t;

  localparam level_t SPURIOUS_LEVEL = 3'd7;

  function automatic level_t onehot_to_level(input logic [7:0] onehot);
    level_t lvl;
    lvl = '0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) lvl = level_t'(i);
    end
    return lvl;
  endfunction

  function automatic logic [7:0] level_to_onehot(input level_t lvl);
    return 8'b1 << lvl;
  endfunction

endpackage

// File: rtl/isr_priority_encoder.sv
// Picks the highest-priority set bit of the in-service register under the
// current rotation. Priority runs from priority_ptr+1 (highest) around to
// priority_ptr (lowest), modulo 8.
//   isr            : in-service bits
//   priority_ptr   : current lowest-priority level
//   highest_onehot : one-hot winner, zero when isr is empty
module isr_priority_encoder
  import pic_pkg::*;
(
  input  logic [7:0] isr,
  input  level_t     priority_ptr,
  output logic [7:0] highest_onehot
);

  logic   w_found;
  level_t w_idx;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    highest_onehot = '0;
    w_found        = 1'b0;
    w_idx          = priority_ptr;
    for (int k = 1; k <= 8; k++) begin
      w_idx = level_t'(priority_ptr + k);
      if (!w_found && isr[w_idx]) begin
        highest_onehot[w_idx] = 1'b1;
        w_found               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/in_service_ack_control.sv
// In-service register and INTA acknowledge sequencer.
// Tracks the two-pulse INTA handshake, sets/clears ISR bits, handles
// specific/non-specific/automatic EOI with optional priority rotation and
// drives the vector byte during the second acknowledge pulse.
//   interrupt                : one-hot winning request (0 = none)
//   inta_n                   : acknowledge, active-low, synchronous to clk
//   eoi_valid/specific/level : end-of-interrupt command strobe
//   rotate_on_eoi, auto_eoi  : EOI mode controls
//   vector_base              : vector bits T7..T3
//   int_out                  : request to CPU
//   in_service_register      : ISR bits
//   highest_level_in_service : one-hot highest ISR bit under rotation
//   clear_irr                : one-cycle pulse for the acknowledged IRR bit
//   data_out, data_out_en    : vector byte and its bus enable
module in_service_ack_control
  import pic_pkg::*;
#(
  parameter int LOWEST_PRIO_RESET = 7
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] interrupt,
  input  logic       inta_n,
  input  logic       eoi_valid,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  input  logic       rotate_on_eoi,
  input  logic       auto_eoi,
  input  logic [4:0] vector_base,
  output logic       int_out,
  output logic [7:0] in_service_register,
  output logic [7:0] highest_level_in_service,
  output logic [7:0] clear_irr,
  output logic [7:0] data_out,
  output logic       data_out_en
);

  ack_state_t r_state;
  logic [7:0] r_isr;
  level_t     r_ptr;
  level_t     r_level;
  logic       r_spurious;
  logic       r_inta_n_d;
  logic       r_int_out;
  logic [7:0] r_clear_irr;
  logic [7:0] r_data_out;
  logic       r_data_out_en;

  logic       w_fall;
  logic       w_rise;
  logic       w_has_int;
  level_t     w_int_level;
  logic [7:0] w_highest;
  logic [7:0] w_eoi_clr;
  logic       w_eoi_rot;
  level_t     w_eoi_rot_lvl;
  logic       w_ack_take;
  logic [7:0] w_ack_set;
  logic       w_auto_done;
  logic [7:0] w_auto_clr;

  isr_priority_encoder u_isr_priority_encoder (
    .isr            (r_isr),
    .priority_ptr   (r_ptr),
    .highest_onehot (w_highest)
  );

  always_comb begin
    w_fall      = r_inta_n_d & ~inta_n;
    w_rise      = ~r_inta_n_d & inta_n;
    w_has_int   = |interrupt;
    w_int_level = onehot_to_level(interrupt);

    w_eoi_clr     = '0;
    w_eoi_rot     = 1'b0;
    w_eoi_rot_lvl = eoi_level;
    if (eoi_valid) begin
      if (eoi_specific) begin
        w_eoi_clr = level_to_onehot(eoi_level);
        w_eoi_rot = rotate_on_eoi;
      end else if (|w_highest) begin
        w_eoi_clr     = w_highest;
        w_eoi_rot     = rotate_on_eoi;
        w_eoi_rot_lvl = onehot_to_level(w_highest);
      end
    end

    // Auto-EOI without rotation never needs the bit, so it is not set at all.
    w_ack_take = (r_state == ST_PENDING) && w_fall && w_has_int;
    w_ack_set  = (w_ack_take && !(auto_eoi && !rotate_on_eoi))
                 ? level_to_onehot(w_int_level) : '0;

    w_auto_done = (r_state == ST_ACK2) && w_rise && auto_eoi && !r_spurious;
    w_auto_clr  = w_auto_done ? level_to_onehot(r_level) : '0;
  end

  assign int_out                  = r_int_out;
  assign in_service_register      = r_isr;
  assign highest_level_in_service = w_highest;
  assign clear_irr                = r_clear_irr;
  assign data_out                 = r_data_out;
  assign data_out_en              = r_data_out_en;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_isr         <= '0;
      r_ptr         <= level_t'(LOWEST_PRIO_RESET);
      r_level       <= '0;
      r_spurious    <= 1'b0;
      r_inta_n_d    <= 1'b1;
      r_int_out     <= 1'b0;
      r_clear_irr   <= '0;
      r_data_out    <= '0;
      r_data_out_en <= 1'b0;
    end else begin
      r_inta_n_d  <= inta_n;
      // Clear before set: an ISR set in the same cycle as an EOI wins.
      r_isr       <= (r_isr & ~(w_eoi_clr | w_auto_clr)) | w_ack_set;
      r_clear_irr <= w_ack_take ? level_to_onehot(w_int_level) : '0;

      // An auto-EOI rotation takes precedence over a coincident EOI command.
      if (w_auto_done && rotate_on_eoi) r_ptr <= r_level;
      else if (w_eoi_rot)               r_ptr <= w_eoi_rot_lvl;

      case (r_state)
        ST_IDLE: begin
          if (w_has_int) begin
            r_state   <= ST_PENDING;
            r_int_out <= 1'b1;
          end
        end
        ST_PENDING: begin
          if (w_fall) begin
            r_state    <= ST_ACK1;
            r_level    <= w_has_int ? w_int_level : SPURIOUS_LEVEL;
            r_spurious <= !w_has_int;
            r_int_out  <= 1'b1;
          end else if (!w_has_int) begin
            r_state   <= ST_IDLE;
            r_int_out <= 1'b0;
          end
        end
        ST_ACK1: begin
          if (w_rise) r_state <= ST_GAP;
        end
        ST_GAP: begin
          if (w_fall) begin
            r_state       <= ST_ACK2;
            r_int_out     <= 1'b0;
            r_data_out    <= {vector_base, r_level};
            r_data_out_en <= 1'b1;
          end
        end
        ST_ACK2: begin
          if (w_rise) begin
            r_state       <= ST_IDLE;
            r_data_out    <= '0;
            r_data_out_en <= 1'b0;
          end else begin
            r_data_out <= {vector_base, r_level};
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_int_out     <= 1'b0;
          r_data_out    <= '0;
          r_data_out_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/in_service_ack_control.md
IN_SERVICE_ACK_CONTROL -- requirements
Module: in_service_ack_control

Interface
REQ-001 The block SHALL have parameter LOWEST_PRIO_RESET, default 7, meaning the lowest-priority level loaded into the rotation pointer at reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 interrupt  input  8  one-hot winning request from the priority resolver; all-zero means none.
REQ-005 inta_n  input  1  CPU interrupt-acknowledge, active-low level, already synchronised to clk.
REQ-006 eoi_valid  input  1  single-cycle end-of-interrupt command strobe.
REQ-007 eoi_specific  input  1  1 means specific EOI for eoi_level; 0 means non-specific EOI.
REQ-008 eoi_level  input  3  level for specific EOI.
REQ-009 rotate_on_eoi  input  1  1 means the cleared level becomes lowest priority.
REQ-010 auto_eoi  input  1  1 means the ISR bit clears at the end of the second INTA.
REQ-011 vector_base  input  5  vector bits T7..T3.
REQ-012 int_out  output  1  interrupt request to the CPU.
REQ-013 in_service_register  output  8  ISR bits.
REQ-014 highest_level_in_service  output  8  one-hot highest-priority set ISR bit under the current rotation; zero if ISR is empty.
REQ-015 clear_irr  output  8  single-cycle one-hot pulse that clears the acknowledged IRR bit.
REQ-016 data_out  output  8  vector byte.
REQ-017 data_out_en  output  1  1 while data_out drives the bus.

Function
REQ-018 The FSM SHALL have states IDLE, PENDING, ACK1, GAP, and ACK2.
REQ-019 IDLE->PENDING SHALL occur when interrupt!=0; int_out SHALL be 1 exactly in PENDING, ACK1 and GAP.
REQ-020 PENDING->IDLE SHALL occur if interrupt returns to 0 before any inta_n falling edge.
REQ-021 A falling edge of inta_n in PENDING SHALL latch the winner level and move to ACK1.
- Same cycle: set the ISR bit unless auto_eoi=1 and rotate_on_eoi=0.
- Same cycle: pulse clear_irr for that bit.
REQ-022 If interrupt==0 at the first falling edge, the block SHALL latch level 7 as spurious, leave ISR unchanged, and issue no clear_irr.
REQ-023 A rising edge of inta_n SHALL move ACK1->GAP; the next falling edge SHALL move GAP->ACK2.
REQ-024 In ACK2, data_out SHALL be {vector_base, latched level} with data_out_en=1, starting the cycle after the falling edge and lasting until the cycle after the inta_n rising edge; the rising edge SHALL then return the FSM to IDLE.
REQ-025 With auto_eoi=1 and a non-spurious level, the rising edge ending ACK2 SHALL clear the ISR bit and apply rotation if rotate_on_eoi=1.
REQ-026 Non-specific EOI SHALL clear the bit indicated by highest_level_in_service; it SHALL be a no-op if ISR is empty.
REQ-027 Specific EOI SHALL clear bit eoi_level, whether set or not.
REQ-028 Rotation SHALL set the pointer to the cleared level; priority order is pointer+1 (highest) wrapping modulo 8 to pointer (lowest).
REQ-029 highest_level_in_service SHALL be combinational from ISR and the pointer.
REQ-030 When eoi_valid coincides with an ISR set, the clear SHALL be applied first and the set second (set wins on the same bit).
REQ-031 eoi_valid SHALL be honoured in every FSM state.
REQ-032 inta_n edges seen in IDLE SHALL be ignored.

Reset
REQ-033 While reset_n=0 at a clock edge, the block SHALL set:
- state IDLE
- ISR 0
- pointer LOWEST_PRIO_RESET
- int_out 0, clear_irr 0, data_out 0, data_out_en 0
- inta_n edge history 1
REQ-034 A reset during any acknowledge state SHALL abandon the cycle with no ISR set and no vector driven in the following cycle.

Structure
REQ-035 Package pic_pkg SHALL hold the FSM state enum, the 3-bit level type, and the one-hot/index conversion functions shared with the priority resolver.
REQ-036 The block SHALL instantiate one sub-module, isr_priority_encoder, which takes ISR and the pointer and returns the one-hot highest in-service level.

Verification
REQ-037 Basic acknowledge: interrupt=8'h04, vector_base=5'h08, two INTA pulses -> int_out 1 until the second falling edge; ISR=8'h04; clear_irr=8'h04 for one cycle; data_out=8'h42.
REQ-038 Spurious acknowledge: interrupt drops to 0 after PENDING and inta_n falls -> ISR unchanged, no clear_irr, data_out={vector_base,3'd7}.
REQ-039 Non-specific EOI with rotation: ISR=8'h28, pointer=7, rotate_on_eoi=1, EOI -> ISR=8'h20, pointer=3, highest_level_in_service=8'h20.
REQ-040 Auto EOI: auto_eoi=1, acknowledge IR1 -> ISR returns to 0 on the second inta_n rising edge, with ISR bit 1 never observed set.
REQ-041 Collision and reset: specific EOI for level 2 in the same cycle as the ISR set for level 2 -> ISR bit 2 = 1; reset_n=0 in GAP -> all outputs 0 next cycle and FSM in IDLE.
